// File: rtl/spi_bridge_pkg.sv
// Shared definitions for the SPI-to-register bridge: FSM state encodings,
// command-byte layout and the default link-check status byte.
package spi_bridge_pkg;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE  = 2'd0;
    localparam state_t ST_CMD   = 2'd1;
    localparam state_t ST_WRITE = 2'd2;
    localparam state_t ST_READ  = 2'd3;

    localparam int unsigned  CMD_WRITE_BIT   = 7;
    localparam logic [7:0]   STATUS_BYTE_DEF = 8'hA5;

    function automatic logic is_write_cmd(input logic [7:0] cmd);
        return cmd[CMD_WRITE_BIT];
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Generic two-flop synchroniser for a single asynchronous level input.
// RST_VAL lets the output come out of reset in the pin's inactive level.
module sync_2ff #(
    parameter logic RST_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic i_d,
    output logic o_q
);

    logic r_meta;
    logic r_sync;

    // Two-stage capture of the asynchronous input
    always_ff @(posedge clk) begin
        if (rst) begin
            r_meta <= RST_VAL;
            r_sync <= RST_VAL;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule

// File: rtl/spi_reg_bridge.sv
// Byte-level SPI command parser: each ss-low frame becomes a burst read or
// write on a synchronous register port, with address auto-increment.
module spi_reg_bridge
    import spi_bridge_pkg::*;
#(
    parameter int unsigned ADDR_W      = 7,
    parameter logic [7:0]  STATUS_BYTE = STATUS_BYTE_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ss,
    input  logic              rx_done,
    input  logic [7:0]        rx_data,
    output logic [7:0]        tx_data,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [7:0]        wr_data,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [7:0]        rd_data,
    output logic              busy
);

    logic              w_ss_s;
    logic [ADDR_W-1:0] w_cmd_addr;
    state_t            w_state_fsm;
    state_t            w_state_nxt;

    state_t            r_state;
    logic              r_busy;
    logic [ADDR_W-1:0] r_addr;
    logic [ADDR_W-1:0] r_rd_addr;
    logic              r_fetch;
    logic              r_cap;
    logic [7:0]        r_tx_data;
    logic              r_wr_en;
    logic [ADDR_W-1:0] r_wr_addr;
    logic [7:0]        r_wr_data;

    sync_2ff #(
        .RST_VAL (1'b1)
    ) u_ss_sync (
        .clk (clk),
        .rst (rst),
        .i_d (ss),
        .o_q (w_ss_s)
    );

    assign w_cmd_addr = rx_data[ADDR_W-1:0];

    // Next-state logic; a deasserted ss_s overrides everything
    always_comb begin
        w_state_fsm = r_state;
        case (r_state)
            ST_IDLE: begin
                if (!w_ss_s) begin
                    w_state_fsm = ST_CMD;
                end else begin
                    w_state_fsm = ST_IDLE;
                end
            end
            ST_CMD: begin
                if (rx_done) begin
                    w_state_fsm = is_write_cmd(rx_data) ? ST_WRITE : ST_READ;
                end else begin
                    w_state_fsm = ST_CMD;
                end
            end
            ST_WRITE: w_state_fsm = ST_WRITE;
            ST_READ:  w_state_fsm = ST_READ;
            default:  w_state_fsm = ST_IDLE;
        endcase
        w_state_nxt = w_ss_s ? ST_IDLE : w_state_fsm;
    end

    // FSM state, write strobe and the two-stage read fetch pipeline.
    // A byte arriving with ss_s rising is still acted on before the abort.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_busy    <= 1'b0;
            r_addr    <= '0;
            r_rd_addr <= '0;
            r_fetch   <= 1'b0;
            r_cap     <= 1'b0;
            r_tx_data <= STATUS_BYTE;
            r_wr_en   <= 1'b0;
            r_wr_addr <= '0;
            r_wr_data <= 8'h00;
        end else begin
            r_state <= w_state_nxt;
            r_busy  <= (w_state_nxt != ST_IDLE);
            r_wr_en <= 1'b0;
            r_fetch <= 1'b0;
            r_cap   <= r_fetch;
            if (r_cap) begin
                r_tx_data <= rd_data;
            end
            case (r_state)
                ST_CMD: begin
                    if (rx_done) begin
                        if (is_write_cmd(rx_data)) begin
                            r_addr <= w_cmd_addr;
                        end else begin
                            r_rd_addr <= w_cmd_addr;
                            r_addr    <= w_cmd_addr + ADDR_W'(1);
                            r_fetch   <= 1'b1;
                        end
                    end
                end
                ST_WRITE: begin
                    if (rx_done) begin
                        r_wr_en   <= 1'b1;
                        r_wr_addr <= r_addr;
                        r_wr_data <= rx_data;
                        r_addr    <= r_addr + ADDR_W'(1);
                    end
                end
                ST_READ: begin
                    if (rx_done) begin
                        r_rd_addr <= r_addr;
                        r_addr    <= r_addr + ADDR_W'(1);
                        r_fetch   <= 1'b1;
                    end
                end
                default: begin
                end
            endcase
            if (w_ss_s) begin
                r_fetch   <= 1'b0;
                r_cap     <= 1'b0;
                r_tx_data <= STATUS_BYTE;
            end
        end
    end

    assign tx_data = r_tx_data;
    assign wr_en   = r_wr_en;
    assign wr_addr = r_wr_addr;
    assign wr_data = r_wr_data;
    assign rd_addr = r_rd_addr;
    assign busy    = r_busy;

endmodule

// File: tb/tb_spi_reg_bridge.sv
// Scoreboard bench for spi_reg_bridge: emulates the SPI byte slave and a
// synchronous 128-byte register file; monitors compare writes and MISO bytes.
module tb_spi_reg_bridge;

    localparam int GAP = 6;

    logic       clk;
    logic       rst;
    logic       ss;
    logic       rx_done;
    logic [7:0] rx_data;
    logic [7:0] tx_data;
    logic       wr_en;
    logic [6:0] wr_addr;
    logic [7:0] wr_data;
    logic [6:0] rd_addr;
    logic [7:0] rd_data;
    logic       busy;

    logic [7:0]  mem [0:127];
    logic [14:0] exp_wr_q [$];
    logic [7:0]  exp_miso_q [$];
    logic [7:0]  act_miso_q [$];

    int n_checks;
    int n_errors;

    spi_reg_bridge #(
        .ADDR_W      (7),
        .STATUS_BYTE (8'hA5)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .ss      (ss),
        .rx_done (rx_done),
        .rx_data (rx_data),
        .tx_data (tx_data),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .rd_addr (rd_addr),
        .rd_data (rd_data),
        .busy    (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous register file: write port plus 1-cycle read latency
    always @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        rd_data <= mem[rd_addr];
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Write monitor: every strobe must match the next expected write
    always @(negedge clk) begin
        if (wr_en === 1'b1) begin
            if (exp_wr_q.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL unexpected_write: got addr %0d data %h expected no write", wr_addr, wr_data);
            end else begin
                check("write", {17'd0, wr_addr, wr_data}, {17'd0, exp_wr_q.pop_front()});
            end
        end
    end

    // MISO monitor: pair each byte the emulated slave shifted out with its expectation
    always @(negedge clk) begin
        if (act_miso_q.size() != 0) begin
            logic [7:0] a;
            a = act_miso_q.pop_front();
            if (exp_miso_q.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL unexpected_miso: got %h expected none", a);
            end else begin
                check("miso", {24'd0, a}, {24'd0, exp_miso_q.pop_front()});
            end
        end
    end

    task automatic frame_begin();
        @(negedge clk);
        ss = 1'b0;
        repeat (4) @(negedge clk);
        act_miso_q.push_back(tx_data);
    endtask

    // One received byte; smp records the din preloaded for the following byte
    task automatic send_byte(input logic [7:0] b, input bit smp);
        repeat (GAP) @(negedge clk);
        if (smp) act_miso_q.push_back(tx_data);
        rx_data = b;
        rx_done = 1'b1;
        @(negedge clk);
        rx_done = 1'b0;
    endtask

    task automatic frame_end();
        repeat (GAP) @(negedge clk);
        ss = 1'b1;
        repeat (4) @(negedge clk);
        check("idle_busy", {31'd0, busy}, 32'd0);
        check("idle_tx", {24'd0, tx_data}, 32'h0000_00A5);
    endtask

    task automatic push_miso(input int n, input logic [7:0] v);
        for (int i = 0; i < n; i++) exp_miso_q.push_back(v);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        n_checks = 0;
        n_errors = 0;
        rst      = 1'b1;
        ss       = 1'b1;
        rx_done  = 1'b0;
        rx_data  = 8'h00;
        repeat (4) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("rst_tx", {24'd0, tx_data}, 32'h0000_00A5);
        check("rst_wr_en", {31'd0, wr_en}, 32'd0);
        check("rst_wr_addr", {25'd0, wr_addr}, 32'd0);
        check("rst_wr_data", {24'd0, wr_data}, 32'd0);
        check("rst_rd_addr", {25'd0, rd_addr}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);

        // Write burst at 5
        exp_wr_q.push_back({7'd5, 8'h11});
        exp_wr_q.push_back({7'd6, 8'h22});
        push_miso(3, 8'hA5);
        frame_begin();
        check("busy_in_frame", {31'd0, busy}, 32'd1);
        send_byte(8'h85, 1'b1);
        send_byte(8'h11, 1'b1);
        send_byte(8'h22, 1'b0);
        frame_end();

        // Load reg[3], reg[4] for the read burst
        exp_wr_q.push_back({7'd3, 8'h3C});
        exp_wr_q.push_back({7'd4, 8'h4D});
        push_miso(3, 8'hA5);
        frame_begin();
        send_byte(8'h83, 1'b1);
        send_byte(8'h3C, 1'b1);
        send_byte(8'h4D, 1'b0);
        frame_end();

        // Read burst from 3
        push_miso(2, 8'hA5);
        exp_miso_q.push_back(8'h3C);
        exp_miso_q.push_back(8'h4D);
        frame_begin();
        send_byte(8'h03, 1'b1);
        send_byte(8'hEE, 1'b1);
        send_byte(8'hEE, 1'b1);
        send_byte(8'hEE, 1'b0);
        frame_end();

        // Write wrapping 127 -> 0
        exp_wr_q.push_back({7'd127, 8'h01});
        exp_wr_q.push_back({7'd0, 8'h02});
        push_miso(3, 8'hA5);
        frame_begin();
        send_byte(8'hFF, 1'b1);
        send_byte(8'h01, 1'b1);
        send_byte(8'h02, 1'b0);
        frame_end();

        // Read wrapping 127 -> 0
        push_miso(2, 8'hA5);
        exp_miso_q.push_back(8'h01);
        exp_miso_q.push_back(8'h02);
        frame_begin();
        send_byte(8'h7F, 1'b1);
        send_byte(8'hEE, 1'b1);
        send_byte(8'hEE, 1'b1);
        send_byte(8'hEE, 1'b0);
        frame_end();

        // Abort after write command, partial data byte never completes
        push_miso(1, 8'hA5);
        frame_begin();
        send_byte(8'h82, 1'b0);
        frame_end();

        // Next frame's first byte is a fresh read command at 4
        push_miso(2, 8'hA5);
        exp_miso_q.push_back(8'h4D);
        frame_begin();
        send_byte(8'h04, 1'b1);
        send_byte(8'hEE, 1'b1);
        send_byte(8'hEE, 1'b0);
        frame_end();

        // Last byte coincides with ss_s rising; then a stray byte while idle
        exp_wr_q.push_back({7'd10, 8'h55});
        exp_wr_q.push_back({7'd11, 8'h66});
        push_miso(3, 8'hA5);
        frame_begin();
        send_byte(8'h8A, 1'b1);
        send_byte(8'h55, 1'b1);
        repeat (GAP) @(negedge clk);
        ss = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rx_data = 8'h66;
        rx_done = 1'b1;
        @(negedge clk);
        rx_done = 1'b0;
        check("coincide_busy", {31'd0, busy}, 32'd0);
        repeat (GAP) @(negedge clk);
        rx_data = 8'h77;
        rx_done = 1'b1;
        @(negedge clk);
        rx_done = 1'b0;
        repeat (4) @(negedge clk);
        check("stray_busy", {31'd0, busy}, 32'd0);
        check("stray_tx", {24'd0, tx_data}, 32'h0000_00A5);

        // Reset in the middle of a read burst
        push_miso(2, 8'hA5);
        frame_begin();
        send_byte(8'h03, 1'b1);
        repeat (4) @(negedge clk);
        check("mid_read_tx", {24'd0, tx_data}, 32'h0000_003C);
        check("mid_read_rd_addr", {25'd0, rd_addr}, 32'd3);
        rst = 1'b1;
        ss  = 1'b1;
        @(negedge clk);
        check("mrst_tx", {24'd0, tx_data}, 32'h0000_00A5);
        check("mrst_wr_en", {31'd0, wr_en}, 32'd0);
        check("mrst_wr_addr", {25'd0, wr_addr}, 32'd0);
        check("mrst_wr_data", {24'd0, wr_data}, 32'd0);
        check("mrst_rd_addr", {25'd0, rd_addr}, 32'd0);
        check("mrst_busy", {31'd0, busy}, 32'd0);
        rst = 1'b0;
        repeat (4) @(negedge clk);
        check("post_rst_busy", {31'd0, busy}, 32'd0);

        repeat (10) @(negedge clk);
        check("wr_queue_drained", exp_wr_q.size(), 32'd0);
        check("miso_queue_drained", exp_miso_q.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
